// File: rtl/func1_vector_gen_if.sv
// Operand-stream bus between the func1 vector generator, its run controller
// and the downstream func1 evaluator.
interface func1_vector_gen_if #(
  parameter int N = 2
);
  localparam int W = 4 * N;

  logic         start;
  logic         abort;
  logic         pause;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic [N-1:0] d;
  logic [W-1:0] vec_idx;
  logic         busy;
  logic         done;

  // Generator side
  modport master (
    input  start, abort, pause, out_ready,
    output out_valid, a, b, c, d, vec_idx, busy, done
  );

  // Controller / evaluator side
  modport slave (
    output start, abort, pause, out_ready,
    input  out_valid, a, b, c, d, vec_idx, busy, done
  );
endinterface

// File: rtl/func1_vector_gen.sv
// Exhaustive operand sequencer for func1: walks vec_idx through 0..2^W-1 once
// per run and presents {a,b,c,d} slices over a valid/ready handshake.
module func1_vector_gen #(
  parameter int N = 2,
  parameter int W = 4 * N
) (
  input  logic               clk,
  input  logic               rst,
  func1_vector_gen_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_idx;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;

  logic         w_xfer;
  logic         w_last;

  assign w_xfer = r_valid & bus.out_ready;
  assign w_last = (r_idx == {W{1'b1}});

  // Run control FSM; every output is a register updated here.
  // Priority: rst > abort > start > pause.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.abort) begin
      // A transfer coinciding with abort is dropped: no increment, no DONE.
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_idx  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            if (bus.pause) begin
              r_state <= S_PAUSED;
              r_valid <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Pause only takes effect at a transfer boundary, so a stalled
          // vector keeps out_valid high until it is accepted.
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
              if (bus.pause) begin
                r_state <= S_PAUSED;
                r_valid <= 1'b0;
              end
            end
          end
        end
        S_PAUSED: begin
          if (!bus.pause) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.vec_idx   = r_idx;
  assign bus.a         = r_idx[4*N-1:3*N];
  assign bus.b         = r_idx[3*N-1:2*N];
  assign bus.c         = r_idx[2*N-1:N];
  assign bus.d         = r_idx[N-1:0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_func1_vector_gen.sv
// Scoreboard bench for func1_vector_gen: each start pushes the full expected
// index sequence of a run; a negedge monitor pops and compares every transfer.
module tb_func1_vector_gen;
  localparam int N    = 2;
  localparam int W    = 4 * N;
  localparam int NVEC = 1 << W;
  localparam int MSK  = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  func1_vector_gen_if #(.N(N)) bus ();

  func1_vector_gen #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int xfers = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: inputs change #1 after posedge, so a negedge sample shows what
  // the next rising edge will see. Abort/rst discard that edge's transfer.
  always @(negedge clk) begin
    if (!rst && !bus.abort && bus.out_valid && bus.out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", int'(bus.vec_idx), -1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("xfer_idx", int'(bus.vec_idx), e);
        check("xfer_a", int'(bus.a), (e >> (3*N)) & MSK);
        check("xfer_b", int'(bus.b), (e >> (2*N)) & MSK);
        check("xfer_c", int'(bus.c), (e >> N) & MSK);
        check("xfer_d", int'(bus.d), e & MSK);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start and queue the whole sweep the run must deliver.
  task automatic do_start(input logic pz);
    exp_q.delete();
    for (int i = 0; i < NVEC; i++) exp_q.push_back(i);
    xfers     = 0;
    bus.start = 1'b1;
    bus.pause = pz;
    step();
    bus.start = 1'b0;
  endtask

  // Run until done; optional random backpressure and pause bursts.
  task automatic run_to_done(input bit rnd, input int budget, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < budget) begin
      if (rnd) begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
        bus.pause     = ($urandom_range(0, 9) == 0);
      end
      step();
      cyc++;
    end
    bus.pause     = 1'b0;
    bus.out_ready = 1'b1;
    check("done_reached", int'(bus.done), 1);
    check("done_valid_low", int'(bus.out_valid), 0);
    check("done_busy_low", int'(bus.busy), 0);
    check("done_idx_hold", int'(bus.vec_idx), NVEC - 1);
    check("run_xfers", xfers, NVEC);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int n;
    n = 0;
    while (!(bus.out_valid && int'(bus.vec_idx) == idx) && n < budget) begin
      step();
      n++;
    end
    check("reach_idx", int'(bus.vec_idx), idx);
  endtask

  initial begin
    int cyc;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.pause     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with start held: start must be ignored.
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_idx", int'(bus.vec_idx), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);

    // Full sweep at one vector per cycle.
    do_start(1'b0);
    check("start_valid", int'(bus.out_valid), 1);
    check("start_idx", int'(bus.vec_idx), 0);
    check("start_busy", int'(bus.busy), 1);
    run_to_done(1'b0, 2000, cyc);
    check("sweep_cycles", cyc, NVEC);

    // Restart from DONE; backpressure at 17, pause at 40, then random.
    do_start(1'b0);
    check("restart_done_clr", int'(bus.done), 0);
    check("restart_valid", int'(bus.out_valid), 1);
    check("restart_idx", int'(bus.vec_idx), 0);
    wait_idx(17, 100);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_idx", int'(bus.vec_idx), 17);
      check("bp_abcd", int'({bus.a, bus.b, bus.c, bus.d}), 8'b00_01_00_01);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_next_idx", int'(bus.vec_idx), 18);
    wait_idx(40, 100);
    bus.pause = 1'b1;
    step();
    check("pause_valid", int'(bus.out_valid), 0);
    check("pause_idx", int'(bus.vec_idx), 41);
    check("pause_busy", int'(bus.busy), 1);
    step();
    step();
    check("pause_hold_valid", int'(bus.out_valid), 0);
    check("pause_hold_idx", int'(bus.vec_idx), 41);
    bus.pause = 1'b0;
    step();
    check("resume_valid", int'(bus.out_valid), 1);
    check("resume_idx", int'(bus.vec_idx), 41);
    run_to_done(1'b1, 5000, cyc);

    // Abort at idx 100 with a transfer pending in the same cycle.
    do_start(1'b0);
    wait_idx(100, 200);
    check("abort_q_left", exp_q.size(), NVEC - 100);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_valid", int'(bus.out_valid), 0);
    check("abort_idx", int'(bus.vec_idx), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    exp_q.delete();

    // Start into PAUSED, then a randomized sweep.
    do_start(1'b1);
    check("spause_valid", int'(bus.out_valid), 0);
    check("spause_busy", int'(bus.busy), 1);
    check("spause_idx", int'(bus.vec_idx), 0);
    step();
    check("spause_start_ign", int'(bus.busy), 1);
    run_to_done(1'b1, 5000, cyc);

    // Sync reset at idx 200 mid-run, with start asserted alongside.
    do_start(1'b0);
    wait_idx(200, 400);
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    check("mrst_valid", int'(bus.out_valid), 0);
    check("mrst_idx", int'(bus.vec_idx), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.done), 0);
    exp_q.delete();
    step();
    check("mrst_stay_idle", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
